hazard_scoreboard: RTL

Issue controller for the decode stage. Tracks pending register writes per architectural register using small in-flight counters. It gates the decode-stage and fetch enables on RAW and counter-overflow hazards, and asks decode to insert a bubble when nothing issues. It also provides a drain handshake so debug/CSR logic can quiesce the pipeline.

---
 rtl/hazard_scoreboard_pkg.sv | 42 ++++
 rtl/hazard_scoreboard_pend_ctr.sv | 55 +++++
 rtl/hazard_scoreboard.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the decode-stage hazard scoreboard: register-file
// geometry, pending-counter sizing, drain FSM states and the NOP control word.
// Optional feature macro used by the design: WB_BYPASS_EN (same-cycle writeback bypass).
package hazard_scoreboard_pkg;

  localparam int N_REGS  = 32;
  localparam int RF_SIZE = $clog2(N_REGS);
  localparam int PEND_W  = 2;
  localparam int CNT_W   = 32;

  localparam logic [RF_SIZE-1:0] RF_ZERO   = {RF_SIZE{1'b0}};
  localparam logic [PEND_W-1:0]  PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0]  PEND_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};
  localparam logic [PEND_W-1:0]  PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  // Issue-control FSM states.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // EX-stage control word; decode loads EX_CTRL_NOP whenever bubble is high.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [3:0] alu_op;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_NOP = '{
    reg_write: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    branch:    1'b0,
    alu_op:    4'd0
  };

endpackage

// File: rtl/hazard_scoreboard_pend_ctr.sv
// One pending-write counter for a single architectural register.
// Increments on issue of a writer, decrements on writeback; simultaneous
// inc/dec leaves the count unchanged. A decrement at zero holds zero and
// raises o_underflow for that cycle.
module hazard_scoreboard_pend_ctr
  import hazard_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [PEND_W-1:0] o_cnt,
  output logic              o_nonzero,
  output logic              o_underflow
);

  logic [PEND_W-1:0] r_cnt;
  logic [PEND_W-1:0] w_cnt_nxt;
  logic              w_full;

  assign w_full      = (r_cnt == PEND_MAX);
  assign o_cnt       = r_cnt;
  assign o_nonzero   = (r_cnt != PEND_ZERO);
  assign o_underflow = i_dec & (r_cnt == PEND_ZERO);

  // Next count: saturate at both ends, cancel simultaneous inc/dec.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_inc && !i_dec) begin
      if (!w_full) begin
        w_cnt_nxt = r_cnt + PEND_ONE;
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end else if (i_dec && !i_inc) begin
      if (r_cnt != PEND_ZERO) begin
        w_cnt_nxt = r_cnt - PEND_ONE;
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= PEND_ZERO;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage issue controller: tracks in-flight register writes, stalls
// on RAW and pending-counter overflow, requests bubbles and supports a
// drain handshake for debug/CSR quiescing.
// Optional macro WB_BYPASS_EN: when defined, a source whose last pending
// write is being written back this cycle does not stall (needs a
// write-through register file).
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_issue_valid,
  input  logic [RF_SIZE-1:0] i_issue_rs1,
  input  logic [RF_SIZE-1:0] i_issue_rs2,
  input  logic               i_issue_rs1_used,
  input  logic               i_issue_rs2_used,
  input  logic [RF_SIZE-1:0] i_issue_rd,
  input  logic               i_issue_reg_write,
  input  logic               i_flush,
  input  logic               i_wb_we,
  input  logic [RF_SIZE-1:0] i_wb_rd,
  input  logic               i_drain_req,
  output logic               o_drained,
  output logic               o_if_en,
  output logic               o_id_en,
  output logic               o_bubble,
  output logic [CNT_W-1:0]   o_stall_cycles,
  output logic               o_err_underflow
);

  logic [N_REGS-1:0][PEND_W-1:0] w_cnt;
  logic [N_REGS-1:0]             w_nonzero;
  logic [N_REGS-1:0]             w_underflow;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_drained;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             r_err_underflow;

  logic w_byp1, w_byp2;
  logic w_raw1, w_raw2, w_ovf, w_hazard, w_block, w_fire, w_all_zero;

  // x0 is never tracked.
  assign w_cnt[0]       = PEND_ZERO;
  assign w_nonzero[0]   = 1'b0;
  assign w_underflow[0] = 1'b0;

  for (genvar r = 1; r < N_REGS; r++) begin : g_pend
    hazard_scoreboard_pend_ctr u_pend_ctr (
      .clk         (clk),
      .rst         (rst),
      .i_inc       (w_fire & i_issue_reg_write & (i_issue_rd == RF_SIZE'(r))),
      .i_dec       (i_wb_we & (i_wb_rd == RF_SIZE'(r))),
      .o_cnt       (w_cnt[r]),
      .o_nonzero   (w_nonzero[r]),
      .o_underflow (w_underflow[r])
    );
  end

`ifdef WB_BYPASS_EN
  assign w_byp1 = i_wb_we & (i_wb_rd == i_issue_rs1) & (w_cnt[i_issue_rs1] == PEND_ONE);
  assign w_byp2 = i_wb_we & (i_wb_rd == i_issue_rs2) & (w_cnt[i_issue_rs2] == PEND_ONE);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  // Hazard detection and issue/enable generation, zero latency.
  always_comb begin
    w_raw1     = i_issue_rs1_used & (i_issue_rs1 != RF_ZERO) &
                 (w_cnt[i_issue_rs1] != PEND_ZERO) & ~w_byp1;
    w_raw2     = i_issue_rs2_used & (i_issue_rs2 != RF_ZERO) &
                 (w_cnt[i_issue_rs2] != PEND_ZERO) & ~w_byp2;
    w_ovf      = i_issue_reg_write & (i_issue_rd != RF_ZERO) &
                 (w_cnt[i_issue_rd] == PEND_MAX);
    w_hazard   = i_issue_valid & (w_raw1 | w_raw2 | w_ovf);
    w_block    = w_hazard | (r_state != ST_RUN);
    w_fire     = i_issue_valid & ~w_block & ~i_flush & ~rst;
    w_all_zero = ~(|w_nonzero);
    o_id_en    = ~w_block & ~rst;
    o_if_en    = ~w_block & ~rst;
    o_bubble   = ~w_fire;
  end

  // Drain FSM next state; emptiness is judged on the registered counters.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (i_drain_req) w_state_nxt = ST_DRAIN;
        else             w_state_nxt = ST_RUN;
      end
      ST_DRAIN: begin
        if (!i_drain_req)    w_state_nxt = ST_RUN;
        else if (w_all_zero) w_state_nxt = ST_DONE;
        else                 w_state_nxt = ST_DRAIN;
      end
      ST_DONE: begin
        if (!i_drain_req) w_state_nxt = ST_RUN;
        else              w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // State register and registered drained flag (tracks DONE exactly).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_drained <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_drained <= (w_state_nxt == ST_DONE);
    end
  end

  // Saturating hazard-stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= {CNT_W{1'b0}};
    end else if (w_hazard && (r_stall_cycles != CNT_MAX)) begin
      r_stall_cycles <= r_stall_cycles + CNT_ONE;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

  // Sticky underflow error, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_underflow <= 1'b0;
    end else if (|w_underflow) begin
      r_err_underflow <= 1'b1;
    end else begin
      r_err_underflow <= r_err_underflow;
    end
  end

  assign o_drained       = r_drained;
  assign o_stall_cycles  = r_stall_cycles;
  assign o_err_underflow = r_err_underflow;

endmodule
